pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter register and fetch sequencer for the single-cycle RISC core.
- Sits directly upstream of the 32-bit `adder`. It drives the adder operands (PC, increment), consumes the adder's sum and carry as the sequential next-PC, and selects between that value and branch/jump redirects.
- Issues instruction-memory fetch requests with a ready handshake.
- Supports a boot delay after reset and a sticky halt.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect (optional feature only).
- INCREMENT, 32'd4, constant driven onto the adder's b operand.
- BOOT_CYCLES, 2, idle cycles after reset release before the first fetch request (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  freezes PC and fetch state while high.
- branch_taken  in  1  redirect request, sampled on an accepted fetch.
- branch_target  in  32  redirect address.
- halt_req  in  1  request to stop fetching.
- imem_ready  in  1  instruction memory accepts the current request.
- add_sum  in  32  sum from the downstream adder.
- add_cout  in  1  carry from the downstream adder.
- add_a  out  32  adder operand a; always equals pc.
- add_b  out  32  adder operand b; always equals INCREMENT.
- pc  out  32  current fetch address.
- imem_req  out  1  fetch request valid.
- halted  out  1  high in HALT.
- pc_wrap  out  1  sticky; set when a sequential advance carried out.
- trap  out  1  one-cycle pulse on a misaligned redirect (feature only).

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst. rst has priority over every other input.
- Reset values: pc=RESET_VECTOR, imem_req=0, halted=0, pc_wrap=0, trap=0, boot counter=0, state=BOOT.
- FSM states: BOOT, FETCH, HALT.
- BOOT:
  - imem_req=0; the counter increments each cycle.
  - When counter==BOOT_CYCLES-1, go to FETCH on the next edge.
  - stall is ignored in BOOT.
- FETCH:
  - imem_req=1 unless stall=1; stall forces imem_req=0 and holds pc and state.
  - A fetch is accepted on an edge where imem_req=1 and imem_ready=1.
  - On acceptance, pc takes the next value the following cycle (latency 1):
    - branch_taken=1 → branch_target;
    - otherwise → add_sum.
  - If a sequential advance occurs with add_cout=1, set pc_wrap (sticky until rst). pc still wraps to add_sum.
  - No acceptance (imem_ready=0): pc and imem_req are held stable; the request is not withdrawn.
- Halt:
  - halt_req is honoured only on an accepted fetch. The pc update for that fetch still occurs, then state goes to HALT.
  - halt_req and branch_taken together on one acceptance: the redirect is applied, then HALT.
- HALT:
  - imem_req=0, halted=1, pc frozen.
  - Exits only via rst.
- Redirect alignment without the feature: branch_target[1:0] is forced to 2'b00 when loaded.
- Reset mid-operation: any outstanding request is abandoned; the next cycle shows the reset values.
- add_a and add_b are combinational from pc and the parameter; no internal addition is performed.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: an accepted redirect with branch_target[1:0]≠0 loads TRAP_VECTOR instead, and trap=1 for exactly the cycle after acceptance.
- Not defined: trap is tied to 0, and low bits are forced to zero as described above.

Decomposition:
- Shared package `riscv_pkg`:
  - state enum (BOOT, FETCH, HALT);
  - XLEN=32;
  - default vector constants.
- One natural sub-module, `pc_next_mux`: combinational selection among add_sum, the aligned branch_target, and TRAP_VECTOR.
- The FSM and registers stay in the top.

Test Plan:
- Reset/boot: hold rst 3 cycles, release → pc=0, imem_req=0 for 2 cycles, then imem_req=1.
- Sequential: imem_ready=1 continuously with the real adder connected → pc reads 0,4,8,C on successive cycles.
- Backpressure and stall:
  - imem_ready=0 for 3 cycles at pc=8 → pc stays 8 with imem_req=1.
  - stall=1 → imem_req=0 and pc held.
- Redirect:
  - branch_taken=1 with target 32'h40 on acceptance → pc=40 next cycle, then 44.
  - With the feature: target 32'h42 → pc=100 and a trap pulse.
- Wrap: force pc=32'hFFFF_FFFC and accept → pc=0 and pc_wrap=1, still 1 after further fetches.
- Halt:
  - halt_req on acceptance at pc=10 → pc=14, halted=1, imem_req=0 thereafter.
  - rst → pc=0, halted=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch front end.
// Default vectors here are overridable per instance.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam logic [XLEN-1:0] DEF_INCREMENT    = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: sequential sum, aligned redirect or trap vector.
// Trap selection exists only when PC_MISALIGN_TRAP_EN is defined.
module pc_next_mux
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic [XLEN-1:0] add_sum,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] aligned;

  assign aligned = branch_target & ~XLEN'(3);

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = branch_taken
                    & (|branch_target[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    next_pc = add_sum;
    if (misaligned)
      next_pc = TRAP_VECTOR;
    else if (branch_taken)
      next_pc = aligned;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer feeding an external adder.
// Optional misaligned-redirect trap: PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter logic [XLEN-1:0] INCREMENT    = DEF_INCREMENT,
  parameter int              BOOT_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            halt_req,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] add_sum,
  input  logic            add_cout,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic [XLEN-1:0] pc,
  output logic            imem_req,
  output logic            halted,
  output logic            pc_wrap,
  output logic            trap
);

  localparam int CW =
    (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(BOOT_CYCLES - 1);

  fetch_state_e    state, state_n;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            mis;
  logic [XLEN-1:0] next_pc;

  assign add_a  = pc;
  assign add_b  = INCREMENT;
  assign accept = (state == FETCH)
                & ~stall & imem_ready;

  pc_next_mux #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_mux (
    .add_sum       (add_sum),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .misaligned    (mis)
  );

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    halted   = 1'b0;
    unique case (state)
      BOOT: begin
        if (cnt == CNT_LAST)
          state_n = FETCH;
      end
      FETCH: begin
        imem_req = ~stall;
        if (accept && halt_req)
          state_n = HALT;
      end
      HALT: halted = 1'b1;
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      cnt     <= '0;
      pc      <= RESET_VECTOR;
      pc_wrap <= 1'b0;
      trap    <= 1'b0;
    end else begin
      state <= state_n;
      trap  <= accept & mis;
      if (state == BOOT)
        cnt <= cnt + 1'b1;
      if (accept)
        pc <= next_pc;
      // carry only matters on a sequential advance
      if (accept && !branch_taken && add_cout)
        pc_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus random bench for pc_fetch_ctrl.
// Reference model tracks boot/fetch/halt with plain arithmetic.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TV   = 32'h0000_0100;
  localparam logic [31:0] INC  = 32'd4;
  localparam int          BOOTN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        halt_req = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] add_sum;
  logic        add_cout;
  logic [31:0] add_a, add_b, pc;
  logic        imem_req, halted, pc_wrap, trap;

  always #5 clk = ~clk;

  // stand-in for the downstream 32-bit adder
  assign {add_cout, add_sum} =
    {1'b0, add_a} + {1'b0, add_b};

  pc_fetch_ctrl #(
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .INCREMENT    (INC),
    .BOOT_CYCLES  (BOOTN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .imem_ready    (imem_ready),
    .add_sum       (add_sum),
    .add_cout      (add_cout),
    .add_a         (add_a),
    .add_b         (add_b),
    .pc            (pc),
    .imem_req      (imem_req),
    .halted        (halted),
    .pc_wrap       (pc_wrap),
    .trap          (trap)
  );

  int vecs = 0;
  int errs = 0;

  logic [31:0] m_pc   = RV;
  int          m_boot = 0;
  bit          m_live = 0;
  bit          m_halt = 0;
  bit          m_wrap = 0;
  bit          m_trap = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s,
                     input bit b, input logic [31:0] t,
                     input bit h, input bit y);
    logic [32:0] seq;
    bit          take;
    @(negedge clk);
    rst = r; stall = s; branch_taken = b;
    branch_target = t; halt_req = h; imem_ready = y;
    m_trap = 0;
    take = m_live && !m_halt && !s && y;
    if (r) begin
      m_pc = RV; m_boot = 0; m_live = 0;
      m_halt = 0; m_wrap = 0;
    end else if (!m_live) begin
      m_boot++;
      if (m_boot == BOOTN) m_live = 1;
    end else if (take) begin
      seq = {1'b0, m_pc} + {1'b0, INC};
      if (b) begin
`ifdef PC_MISALIGN_TRAP_EN
        if (t % 4 != 0) begin
          m_pc = TV; m_trap = 1;
        end else
          m_pc = t;
`else
        m_pc = t - (t % 4);
`endif
      end else begin
        m_pc = seq[31:0];
        if (seq[32]) m_wrap = 1;
      end
      if (h) m_halt = 1;
    end
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("imem_req", 32'(imem_req),
          32'(m_live && !m_halt && !s));
    check("halted", 32'(halted), 32'(m_halt));
    check("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
    check("trap", 32'(trap), 32'(m_trap));
    check("add_a", add_a, m_pc);
    check("add_b", add_b, INC);
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 32'h0, 0, 1);
  endtask

  initial begin
    repeat (3) cyc(1, 0, 0, 32'h0, 0, 1);
    check("rst_pc", pc, 32'h0);
    go(1);
    check("boot_req", 32'(imem_req), 32'h0);
    go(1);
    check("first_req", 32'(imem_req), 32'h1);
    go(2);
    check("seq_pc8", pc, 32'h8);
    repeat (3) cyc(0, 0, 0, 32'h0, 0, 0);
    check("bp_pc", pc, 32'h8);
    check("bp_req", 32'(imem_req), 32'h1);
    repeat (2) cyc(0, 1, 0, 32'h0, 0, 1);
    check("stall_pc", pc, 32'h8);
    cyc(0, 0, 1, 32'h40, 0, 1);
    check("br_pc", pc, 32'h40);
    go(1);
    check("br_seq", pc, 32'h44);
    cyc(0, 0, 1, 32'h42, 0, 1);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_pc", pc, 32'h100);
    check("mis_trap", 32'(trap), 32'h1);
`else
    check("mis_pc", pc, 32'h40);
`endif
    go(1);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    go(1);
    check("wrap_pc", pc, 32'h0);
    check("wrap_flag", 32'(pc_wrap), 32'h1);
    go(2);
    check("wrap_sticky", 32'(pc_wrap), 32'h1);
    cyc(0, 0, 1, 32'h10, 0, 1);
    cyc(0, 0, 0, 32'h0, 1, 1);
    check("halt_pc", pc, 32'h14);
    check("halt_flag", 32'(halted), 32'h1);
    go(3);
    check("halt_hold", pc, 32'h14);
    cyc(1, 0, 0, 32'h0, 0, 1);
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_h", 32'(halted), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      tg = $urandom;
      if ($urandom_range(0, 3) == 0)
        tg = 32'hFFFF_FFF0 | (tg & 32'hF);
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          tg,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
